// File: rtl/unidad_control_multiciclo.sv
// Multicycle MIPS-subset control unit: Moore FSM driving the shared-memory datapath,
// with memory-ready handshake, illegal-opcode pulse and retired-instruction counter.
module unidad_control_multiciclo #(
    parameter int unsigned OP_W     = 6,
    parameter int unsigned ALUOP_W  = 3,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned WAIT_MEM = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    OP,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemToReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] ALUOP,
    output logic [3:0]         state,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11
    } state_t;

    localparam logic [OP_W-1:0]    OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0]    OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0]    OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0]    OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0]    OP_J     = OP_W'(6'b000010);
    localparam logic [OP_W-1:0]    OP_ADDI  = OP_W'(6'b001000);

    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_FUNC = ALUOP_W'(3'b010);

    state_t           r_state;
    logic [CNT_W-1:0] r_retired;
    logic             w_ready;

    // With WAIT_MEM=0 the memory is assumed single-cycle and mem_ready is ignored.
    assign w_ready = (WAIT_MEM != 0) ? mem_ready : 1'b1;
    assign state   = r_state;
    assign retired = r_retired;

    // State sequencing; every non-DECODE transition into FETCH retires an instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_ready) r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (OP == OP_RTYPE)                  r_state <= S_R_EXEC;
                    else if (OP == OP_LW || OP == OP_SW) r_state <= S_MEM_ADDR;
                    else if (OP == OP_BEQ)               r_state <= S_BRANCH;
                    else if (OP == OP_J)                 r_state <= S_JUMP;
                    else if (OP == OP_ADDI)              r_state <= S_I_EXEC;
                    else                                 r_state <= S_FETCH;
                end
                S_MEM_ADDR: begin
                    r_state <= (OP == OP_SW) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    if (w_ready) r_state <= S_MEM_WB;
                end
                S_MEM_WR: begin
                    if (w_ready) begin
                        r_state   <= S_FETCH;
                        r_retired <= r_retired + CNT_W'(1);
                    end
                end
                S_R_EXEC: r_state <= S_R_WB;
                S_I_EXEC: r_state <= S_I_WB;
                default: begin
                    // MEM_WB, R_WB, BRANCH, JUMP, I_WB and unused encodings all return to FETCH.
                    r_state   <= S_FETCH;
                    r_retired <= r_retired + CNT_W'(1);
                end
            endcase
        end
    end

    // Moore output decode; only FETCH's IRWrite/PCWrite look at the memory handshake.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUOP       = ALU_ADD;
        illegal_op  = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = w_ready;
                PCWrite = w_ready;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                illegal_op = !(OP == OP_RTYPE || OP == OP_LW || OP == OP_SW ||
                               OP == OP_BEQ || OP == OP_J || OP == OP_ADDI);
            end
            S_MEM_ADDR, S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOP   = ALU_FUNC;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOP       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_I_WB: RegWrite = 1'b1;
            default: ;
        endcase
        // Reset silences the datapath immediately, even mid-instruction.
        if (rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemToReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            PCSource    = 2'b00;
            ALUOP       = ALU_ADD;
            illegal_op  = 1'b0;
        end
    end

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Directed vector bench for unidad_control_multiciclo: a per-cycle table for the default
// configuration plus a CNT_W=2 / WAIT_MEM=0 instance for counter wrap and no-stall fetch.
module tb_unidad_control_multiciclo;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] ctl;
        logic        ill;
        logic [15:0] ret;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: default parameters.
    logic        rst, mem_ready;
    logic [5:0]  op;
    logic        pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, ill;
    logic [1:0]  asb, pcs;
    logic [2:0]  aluop;
    logic [3:0]  st;
    logic [15:0] ret;

    unidad_control_multiciclo u_dut (
        .clk(clk), .rst(rst), .OP(op), .mem_ready(mem_ready),
        .PCWrite(pcw), .PCWriteCond(pcwc), .IorD(iord), .MemRead(mr), .MemWrite(mw),
        .IRWrite(irw), .MemToReg(m2r), .RegDst(rdst), .RegWrite(rw), .ALUSrcA(asa),
        .ALUSrcB(asb), .PCSource(pcs), .ALUOP(aluop), .state(st), .illegal_op(ill),
        .retired(ret)
    );

    // Small instance: 2-bit counter, memory handshake ignored.
    logic        rst2, mem_ready2;
    logic [5:0]  op2;
    logic        pcw2, pcwc2, iord2, mr2, mw2, irw2, m2r2, rdst2, rw2, asa2, ill2;
    logic [1:0]  asb2, pcs2;
    logic [2:0]  aluop2;
    logic [3:0]  st2;
    logic [1:0]  ret2;

    unidad_control_multiciclo #(.OP_W(6), .ALUOP_W(3), .CNT_W(2), .WAIT_MEM(0)) u_small (
        .clk(clk), .rst(rst2), .OP(op2), .mem_ready(mem_ready2),
        .PCWrite(pcw2), .PCWriteCond(pcwc2), .IorD(iord2), .MemRead(mr2), .MemWrite(mw2),
        .IRWrite(irw2), .MemToReg(m2r2), .RegDst(rdst2), .RegWrite(rw2), .ALUSrcA(asa2),
        .ALUSrcB(asb2), .PCSource(pcs2), .ALUOP(aluop2), .state(st2), .illegal_op(ill2),
        .retired(ret2)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t tv[$];

    function automatic logic [16:0] mk(input logic p_pcw, input logic p_pcwc, input logic p_iord,
                                       input logic p_mr, input logic p_mw, input logic p_irw,
                                       input logic p_m2r, input logic p_rdst, input logic p_rw,
                                       input logic p_asa, input logic [1:0] p_asb,
                                       input logic [1:0] p_pcs, input logic [2:0] p_alu);
        return {p_pcw, p_pcwc, p_iord, p_mr, p_mw, p_irw, p_m2r, p_rdst, p_rw,
                p_asa, p_asb, p_pcs, p_alu};
    endfunction

    //                    pcw pcwc iord mr mw irw m2r rdst rw asa asb    pcs    aluop
    logic [16:0] C_ZERO, C_FETCH_R, C_FETCH_NR, C_DEC, C_MADDR, C_MRD, C_MWB, C_MWR,
                 C_REX, C_RWB, C_BR, C_J, C_IEX, C_IWB;

    task automatic add(input logic r, input logic [5:0] o, input logic d, input logic [3:0] s,
                       input logic [16:0] c, input logic i, input logic [15:0] n);
        vec_t v;
        v.rst = r; v.op = o; v.rdy = d; v.st = s; v.ctl = c; v.ill = i; v.ret = n;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                           BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

    initial begin
        C_ZERO     = mk(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b000);
        C_FETCH_R  = mk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,3'b000);
        C_FETCH_NR = mk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,3'b000);
        C_DEC      = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b000);
        C_MADDR    = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b000);
        C_MRD      = mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,3'b000);
        C_MWB      = mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000);
        C_MWR      = mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,3'b000);
        C_REX      = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b010);
        C_RWB      = mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,3'b000);
        C_BR       = mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b001);
        C_J        = mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b10,3'b000);
        C_IEX      = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b000);
        C_IWB      = mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b000);

        //   rst op    rdy  state ctl        ill retired
        add(1, R,    1, 0,  C_ZERO,     0, 0);   // reset state
        // R-type: 0,1,6,7,0
        add(0, R,    1, 0,  C_FETCH_R,  0, 0);
        add(0, R,    1, 1,  C_DEC,      0, 0);
        add(0, R,    1, 6,  C_REX,      0, 0);
        add(0, R,    1, 7,  C_RWB,      0, 0);
        // lw with three wait cycles in MEM_RD
        add(0, LW,   1, 0,  C_FETCH_R,  0, 1);
        add(0, LW,   1, 1,  C_DEC,      0, 1);
        add(0, LW,   1, 2,  C_MADDR,    0, 1);
        add(0, LW,   0, 3,  C_MRD,      0, 1);
        add(0, LW,   0, 3,  C_MRD,      0, 1);
        add(0, LW,   0, 3,  C_MRD,      0, 1);
        add(0, LW,   1, 3,  C_MRD,      0, 1);
        add(0, LW,   1, 4,  C_MWB,      0, 1);
        // sw with one wait cycle, then fetch stall, then beq
        add(0, SW,   1, 0,  C_FETCH_R,  0, 2);
        add(0, SW,   1, 1,  C_DEC,      0, 2);
        add(0, SW,   1, 2,  C_MADDR,    0, 2);
        add(0, SW,   0, 5,  C_MWR,      0, 2);
        add(0, SW,   1, 5,  C_MWR,      0, 2);
        add(0, BEQ,  0, 0,  C_FETCH_NR, 0, 3);
        add(0, BEQ,  1, 0,  C_FETCH_R,  0, 3);
        add(0, BEQ,  1, 1,  C_DEC,      0, 3);
        add(0, BEQ,  1, 8,  C_BR,       0, 3);
        // illegal opcode: pulse, not counted
        add(0, BAD,  1, 0,  C_FETCH_R,  0, 4);
        add(0, BAD,  1, 1,  C_DEC,      1, 4);
        // addi then j
        add(0, ADDI, 1, 0,  C_FETCH_R,  0, 4);
        add(0, ADDI, 1, 1,  C_DEC,      0, 4);
        add(0, ADDI, 1, 10, C_IEX,      0, 4);
        add(0, ADDI, 1, 11, C_IWB,      0, 4);
        add(0, J,    1, 0,  C_FETCH_R,  0, 5);
        add(0, J,    1, 1,  C_DEC,      0, 5);
        add(0, J,    1, 9,  C_J,        0, 5);
        // sw aborted by reset during the MEM_WR hold
        add(0, SW,   1, 0,  C_FETCH_R,  0, 6);
        add(0, SW,   1, 1,  C_DEC,      0, 6);
        add(0, SW,   1, 2,  C_MADDR,    0, 6);
        add(0, SW,   0, 5,  C_MWR,      0, 6);
        add(1, SW,   0, 5,  C_ZERO,     0, 6);
        add(1, SW,   1, 0,  C_ZERO,     0, 0);
        // reset masks illegal_op in DECODE
        add(0, BAD,  1, 0,  C_FETCH_R,  0, 0);
        add(1, BAD,  1, 1,  C_ZERO,     0, 0);
        add(0, R,    1, 0,  C_FETCH_R,  0, 0);

        rst = 1'b1; op = R; mem_ready = 1'b1;
        rst2 = 1'b1; op2 = J; mem_ready2 = 1'b0;
        repeat (2) @(posedge clk);

        foreach (tv[i]) begin
            @(negedge clk);
            rst = tv[i].rst; op = tv[i].op; mem_ready = tv[i].rdy;
            #1;
            chk("state",      i, 32'(st),  32'(tv[i].st));
            chk("ctrl",       i, 32'({pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, pcs, aluop}),
                32'(tv[i].ctl));
            chk("illegal_op", i, 32'(ill), 32'(tv[i].ill));
            chk("retired",    i, 32'(ret), 32'(tv[i].ret));
        end

        // Five jumps on the small instance with mem_ready low: no stall, counter wraps.
        @(negedge clk);
        rst2 = 1'b0;
        #1;
        chk("small_reset_ret", 0, 32'(ret2), 32'(0));
        for (int k = 0; k < 16; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            case (k % 3)
                0: begin
                    chk("small_state_fetch", k, 32'(st2), 32'(0));
                    chk("small_irwrite", k, 32'({irw2, pcw2}), 32'(2'b11));
                    chk("small_retired", k, 32'(ret2), 32'((k / 3) % 4));
                end
                1: chk("small_state_dec", k, 32'(st2), 32'(1));
                default: chk("small_state_jump", k, 32'({st2, pcw2, pcs2}), 32'({4'd9, 1'b1, 2'b10}));
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
